instruction_fetch_queue: RTL and testbench

INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

---
 rtl/instruction_fetch_queue_pkg.sv | 14 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/instruction_fetch_queue.sv | 91 +++++++++
 tb/tb_instruction_fetch_queue.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: fetch FSM states, reset PC
// and instruction width.
package instruction_fetch_queue_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDrop
  } fetch_state_e;

  localparam logic [31:0] PC_RESET = 32'h0040_0000;
  localparam int unsigned INSTR_W  = 32;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read and a synchronous clear.
// The caller guarantees no push when full and no pop when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: issues one instruction-memory request at a time, queues
// {pc, instr} responses for decode, and discards in-flight responses on flush.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           PCValue,
  output logic                   pc_enable,
  output logic                   imem_req,
  output logic [N-1:0]           imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_W-1:0]     imem_rdata,
  input  logic                   flush,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INSTR_W-1:0]     dec_instr,
  output logic [N-1:0]           dec_pc,
  output logic [N-1:0]           dec_pc_plus4,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CNW = $clog2(DEPTH) + 2;

  fetch_state_e         state_q, state_d;
  logic [N-1:0]         addr_q;
  logic                 push, pop, issue;
  logic [CNW-1:0]       count_next;
  logic [N+INSTR_W-1:0] head;

  assign pop        = dec_valid & dec_ready;
  assign push       = (state_q == StReq) & imem_ack & ~flush;
  assign count_next = CNW'(count) + CNW'(push) - CNW'(pop);
  // A new request is only issued when its response is guaranteed a free slot.
  assign issue      = reset & ~flush
                    & ((state_q == StIdle) | ((state_q == StReq) & imem_ack))
                    & (count_next < CNW'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (issue) state_d = StReq;
      StReq: begin
        if (flush)         state_d = imem_ack ? StIdle : StDrop;
        else if (imem_ack) state_d = issue ? StReq : StIdle;
      end
      StDrop: if (imem_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req  = (state_q != StIdle);
    pc_enable = issue | flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     addr_q <= '0;
    else if (issue) addr_q <= PCValue;
  end

  assign imem_addr = addr_q;

  sync_fifo #(
    .WIDTH (N + INSTR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({addr_q, imem_rdata}),
    .rdata (head),
    .count (count)
  );

  assign dec_valid    = (count != '0);
  assign dec_pc       = head[N+INSTR_W-1:INSTR_W];
  assign dec_instr    = head[INSTR_W-1:0];
  assign dec_pc_plus4 = dec_pc + N'(4);

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with a PC-register model, a
// variable-latency memory responder and an expected-PC scoreboard.
module tb_instruction_fetch_queue;
  import instruction_fetch_queue_pkg::*;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] PCValue;
  logic         pc_enable;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         flush;
  logic         dec_valid;
  logic         dec_ready;
  logic [31:0]  dec_instr;
  logic [N-1:0] dec_pc;
  logic [N-1:0] dec_pc_plus4;
  logic [2:0]   count;

  logic [N-1:0] pc_q;
  logic [N-1:0] target;

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned lat = 1;
  int unsigned wait_cnt = 0;
  int pop_cnt = 0;
  int issue_cnt = 0;
  int base;
  logic req_s, ack_s, pe_s, flush_s;
  logic [N-1:0] held_addr;
  logic [N-1:0] sb [$];

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PCValue      (PCValue),
    .pc_enable    (pc_enable),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_instr    (dec_instr),
    .dec_pc       (dec_pc),
    .dec_pc_plus4 (dec_pc_plus4),
    .count        (count)
  );

  // PC register: loads target on flush, otherwise PC+4, whenever enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         pc_q <= PC_RESET;
    else if (pc_enable) pc_q <= flush ? target : pc_q + 32'd4;
  end
  assign PCValue = pc_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: memory responds at the negedge, outputs sampled just after it,
  // bookkeeping updated just after the posedge.
  task automatic cycle();
    logic [N-1:0] e;
    @(negedge clk);
    imem_ack   = imem_req && (wait_cnt + 1 >= lat);
    imem_rdata = ~imem_addr;
    #1;
    req_s   = imem_req;
    ack_s   = imem_ack;
    pe_s    = pc_enable;
    flush_s = flush;
    if (dec_valid && dec_ready && !flush) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL unexpected_pop: observed pc %0h expected no pop", dec_pc);
      end else begin
        e = sb.pop_front();
        chk("dec_pc", {32'd0, dec_pc}, {32'd0, e});
        chk("dec_instr", {32'd0, dec_instr}, {32'd0, ~e});
        chk("dec_pc_plus4", {32'd0, dec_pc_plus4}, {32'd0, e + 32'd4});
        pop_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (req_s && !ack_s) wait_cnt++;
    else                 wait_cnt = 0;
    if (pe_s && !flush_s) issue_cnt++;
    if (flush_s) sb.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_imem_req"}, {63'd0, imem_req}, 64'd0);
    chk({tag, "_imem_addr"}, {32'd0, imem_addr}, 64'd0);
    chk({tag, "_dec_valid"}, {63'd0, dec_valid}, 64'd0);
    chk({tag, "_count"}, {61'd0, count}, 64'd0);
    chk({tag, "_pc_enable"}, {63'd0, pc_enable}, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b0;
    flush     = 1'b0;
    dec_ready = 1'b0;
    imem_ack  = 1'b0;
    wait_cnt  = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset(tag);
    reset     = 1'b1;
    issue_cnt = 0;
    pop_cnt   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    flush      = 1'b0;
    dec_ready  = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    target     = '0;

    // Streaming with 1-cycle ack; runs past DEPTH entries so pointers wrap.
    do_reset("rst1");
    lat       = 1;
    dec_ready = 1'b1;
    for (int k = 0; k < 6; k++) sb.push_back(PC_RESET + 32'(4 * k));
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("p1_pc_enable", {63'd0, pe_s}, 64'd1);
      if (i == 0) chk("p1_first_addr", {32'd0, imem_addr}, {32'd0, PC_RESET});
    end
    for (int i = 0; i < 30 && pop_cnt < 6; i++) cycle();
    chk("p1_pops", 64'(pop_cnt), 64'd6);

    // Decode stalled: queue fills to DEPTH and fetch stops.
    do_reset("rst2");
    lat = 1;
    for (int k = 0; k < 4; k++) sb.push_back(PC_RESET + 32'(4 * k));
    repeat (8) cycle();
    chk("p2_count", {61'd0, count}, 64'd4);
    chk("p2_pc_enable", {63'd0, pc_enable}, 64'd0);
    chk("p2_imem_req", {63'd0, imem_req}, 64'd0);
    chk("p2_pc_frozen", {32'd0, pc_q}, 64'h0040_0010);
    chk("p2_issues", 64'(issue_cnt), 64'd4);

    // One pop from full allows exactly one more fetch.
    sb.push_back(32'h0040_0010);
    base      = issue_cnt;
    dec_ready = 1'b1;
    cycle();
    chk("p3_pop", 64'(pop_cnt), 64'd1);
    chk("p3_count_after_pop", {61'd0, count}, 64'd3);
    dec_ready = 1'b0;
    repeat (5) cycle();
    chk("p3_count_refill", {61'd0, count}, 64'd4);
    chk("p3_one_issue", 64'(issue_cnt - base), 64'd1);

    // Flush with a request outstanding; its late response must be dropped.
    do_reset("rst4");
    lat = 3;
    cycle();
    flush  = 1'b1;
    target = 32'h0040_0100;
    cycle();
    chk("p4_flush_pc_enable", {63'd0, pe_s}, 64'd1);
    flush     = 1'b0;
    held_addr = imem_addr;
    chk("p4_count_clear", {61'd0, count}, 64'd0);
    chk("p4_dec_valid", {63'd0, dec_valid}, 64'd0);
    chk("p4_drop_req", {63'd0, imem_req}, 64'd1);
    cycle();
    chk("p4_addr_held", {32'd0, imem_addr}, {32'd0, held_addr});
    cycle();
    chk("p4_drop_done_req", {63'd0, imem_req}, 64'd0);
    chk("p4_no_push", {61'd0, count}, 64'd0);
    sb.push_back(32'h0040_0100);
    dec_ready = 1'b1;
    cycle();
    chk("p4_target_addr", {32'd0, imem_addr}, 64'h0040_0100);
    base = pop_cnt;
    for (int i = 0; i < 20 && pop_cnt == base; i++) cycle();
    chk("p4_target_popped", 64'(pop_cnt - base), 64'd1);
    dec_ready = 1'b0;

    // Flush coinciding with ack and decode accept; target near top of address space.
    for (int i = 0; i < 30 && !(imem_req && wait_cnt == lat - 1 && dec_valid); i++) cycle();
    flush     = 1'b1;
    dec_ready = 1'b1;
    target    = 32'hFFFF_FFFC;
    cycle();
    chk("p5_ack_in_flush", {63'd0, ack_s}, 64'd1);
    chk("p5_pc_enable", {63'd0, pe_s}, 64'd1);
    flush     = 1'b0;
    dec_ready = 1'b0;
    chk("p5_count_clear", {61'd0, count}, 64'd0);
    chk("p5_dec_valid", {63'd0, dec_valid}, 64'd0);
    chk("p5_idle", {63'd0, imem_req}, 64'd0);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000);
    dec_ready = 1'b1;
    base      = pop_cnt;
    for (int i = 0; i < 30 && pop_cnt - base < 2; i++) cycle();
    chk("p5_wrap_pops", 64'(pop_cnt - base), 64'd2);
    dec_ready = 1'b0;

    // Reset asserted mid-request with two entries queued.
    for (int i = 0; i < 40 && !(count == 3'd2 && imem_req); i++) cycle();
    chk("p6_setup", {63'd0, (count == 3'd2 && imem_req)}, 64'd1);
    reset = 1'b0;
    #1;
    check_reset("p6_async");
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    wait_cnt  = 0;
    imem_ack  = 1'b0;
    pop_cnt   = 0;
    reset     = 1'b1;
    sb.push_back(PC_RESET);
    dec_ready = 1'b1;
    cycle();
    chk("p6_first_fetch", {32'd0, imem_addr}, {32'd0, PC_RESET});
    for (int i = 0; i < 20 && pop_cnt == 0; i++) cycle();
    chk("p6_first_pop", 64'(pop_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
